// File: rtl/uart_dual_tx_pkg.sv
// Shared definitions for the dual-lane UART transmitter: FSM state encoding,
// the memory-mapped UART address and the default bit period.
package uart_dual_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   localparam logic [31:0] UART_ADDR            = 32'h1000_0000;
   localparam int          DEFAULT_CLKS_PER_BIT = 1085;

endpackage

// File: rtl/uart_fifo2w.sv
// Two-write / one-read byte FIFO. Lane 1 is stored ahead of lane 2. Bytes that
// do not fit are dropped and latched into a sticky overflow flag.
module uart_fifo2w
   import uart_dual_tx_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int PTR_W      = 4
) (
   input  logic             CLK,
   input  logic             NRST,
   input  logic             we1,
   input  logic [7:0]       data1,
   input  logic             we2,
   input  logic [7:0]       data2,
   input  logic             pop,
   output logic [7:0]       head,
   output logic [PTR_W:0]   count,
   output logic             stall_req,
   output logic             overflow
);

   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [7:0]       mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             overflow_q, overflow_d;
   logic [PTR_W:0]   free;
   logic             push1, push2, pop_ok;

   always_comb begin
      // Credit comes only from the pre-edge count; a same-cycle pop does not help.
      free     = DEPTH_C - count_q;
      push1    = we1 && (free != '0);
      push2    = we2 && (we1 ? (free >= (PTR_W+1)'(2)) : (free != '0));
      pop_ok   = pop && (count_q != '0);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      if (push1) begin
         mem_d[wr_ptr_d] = data1;
         wr_ptr_d        = wr_ptr_d + PTR_W'(1);
      end
      if (push2) begin
         mem_d[wr_ptr_d] = data2;
         wr_ptr_d        = wr_ptr_d + PTR_W'(1);
      end
      rd_ptr_d   = rd_ptr_q + PTR_W'(pop_ok);
      count_d    = count_q + (PTR_W+1)'(push1) + (PTR_W+1)'(push2) - (PTR_W+1)'(pop_ok);
      overflow_d = overflow_q | (we1 & ~push1) | (we2 & ~push2);
   end

   always_ff @(posedge CLK) begin
      if (!NRST) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge CLK) begin
      mem_q <= mem_d;
   end

   assign head      = mem_q[rd_ptr_q];
   assign count     = count_q;
   assign stall_req = (count_q > (DEPTH_C - (PTR_W+1)'(2)));
   assign overflow  = overflow_q;

endmodule

// File: rtl/uart_dual_tx.sv
// Dual-lane UART transmitter: buffers up to two store bytes per cycle and
// serialises them as back-to-back 8N1 frames on a registered tx line.
module uart_dual_tx
   import uart_dual_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 16,
   parameter int PTR_W        = 4
) (
   input  logic       CLK,
   input  logic       NRST,
   input  logic       we1,
   input  logic [7:0] data1,
   input  logic       we2,
   input  logic [7:0] data2,
   output logic       stall_req,
   output logic       overflow,
   output logic       busy,
   output logic       uart_tx
);

   localparam int              BAUD_W    = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   tx_state_e         state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              pop, bit_end;
   logic [7:0]        head;
   logic [PTR_W:0]    count;

   uart_fifo2w #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .PTR_W      (PTR_W)
   ) u_fifo (
      .CLK       (CLK),
      .NRST      (NRST),
      .we1       (we1),
      .data1     (data1),
      .we2       (we2),
      .data2     (data2),
      .pop       (pop),
      .head      (head),
      .count     (count),
      .stall_req (stall_req),
      .overflow  (overflow)
   );

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      bit_end = (baud_q == BAUD_LAST);
      case (state_q)
         ST_IDLE: begin
            if (count != '0) begin
               pop     = 1'b1;
               shift_d = head;
               baud_d  = '0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) begin
               baud_d  = '0;
               bit_d   = 3'd0;
               state_d = ST_DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               baud_d = '0;
               // Chain straight into the next start bit so queued bytes leave no idle gap.
               if (count != '0) begin
                  pop     = 1'b1;
                  shift_d = head;
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      case (state_q)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shift_q[0];
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!NRST) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   assign uart_tx = tx_q;
   assign busy    = (count != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_dual_tx.sv
// Directed bench for uart_dual_tx with a byte scoreboard and a frame decoder.
module tb_uart_dual_tx;

   logic       CLK = 1'b0;
   logic       NRST = 1'b0;
   logic       we1 = 1'b0, we2 = 1'b0;
   logic [7:0] data1 = '0, data2 = '0;
   logic       stall_req, overflow, busy, uart_tx;

   int checks   = 0;
   int failures = 0;
   logic [7:0] sb[$];

   uart_dual_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PTR_W(2)) dut (
      .CLK(CLK), .NRST(NRST), .we1(we1), .data1(data1), .we2(we2), .data2(data2),
      .stall_req(stall_req), .overflow(overflow), .busy(busy), .uart_tx(uart_tx)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change at a falling edge and are sampled at the following rising edge.
   task automatic drive(input logic w1, input logic [7:0] d1, input logic w2, input logic [7:0] d2);
      @(negedge CLK);
      we1 = w1; data1 = d1; we2 = w2; data2 = d2;
      @(posedge CLK);
      #1;
      we1 = 1'b0; we2 = 1'b0;
   endtask

   // Waits for a start bit, checks the full 40-cycle waveform against the head of the scoreboard.
   task automatic recv_frame(input string tag, output int lat);
      logic [7:0] exp_b, got;
      int bad;
      logic e;
      lat = 0;
      got = '0;
      bad = 0;
      @(negedge CLK);
      while (uart_tx !== 1'b0 && lat < 200) begin
         lat++;
         @(negedge CLK);
      end
      if (lat >= 200) begin
         check({tag, "_timeout"}, 32'(lat), 32'd0);
         return;
      end
      exp_b = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      for (int p = 0; p < 40; p++) begin
         if (p > 0) @(negedge CLK);
         if (p < 4)       e = 1'b0;
         else if (p < 36) e = exp_b[(p-4)/4];
         else             e = 1'b1;
         if (uart_tx !== e) bad++;
         if (p >= 4 && p < 36 && ((p-4) % 4) == 2) got[(p-4)/4] = uart_tx;
      end
      $display("frame %s: got=%02h expected=%02h lat=%0d", tag, got, exp_b, lat);
      check({tag, "_byte"}, 32'(got), 32'(exp_b));
      check({tag, "_shape"}, 32'(bad), 32'd0);
   endtask

   initial begin
      int lat;
      int bad;

      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_tx", 32'(uart_tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_stall", 32'(stall_req), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      NRST = 1'b1;
      repeat (2) @(negedge CLK);

      // 1: single lane-1 byte, start bit two edges after the write
      drive(1'b1, 8'h55, 1'b0, 8'h00);
      sb.push_back(8'h55);
      check("t1_busy_after_push", 32'(busy), 32'd1);
      recv_frame("t1", lat);
      check("t1_lat", 32'(lat), 32'd2);
      @(negedge CLK);
      check("t1_busy_end", 32'(busy), 32'd0);
      check("t1_tx_idle", 32'(uart_tx), 32'd1);

      // 2: dual write in one cycle, lane 1 first, back-to-back frames
      drive(1'b1, 8'h41, 1'b1, 8'h42);
      sb.push_back(8'h41);
      sb.push_back(8'h42);
      recv_frame("t2a", lat);
      check("t2a_lat", 32'(lat), 32'd2);
      recv_frame("t2b", lat);
      check("t2b_gap", 32'(lat), 32'd0);
      @(negedge CLK);
      check("t2_ovf", 32'(overflow), 32'd0);
      check("t2_busy_end", 32'(busy), 32'd0);

      // 3 and 4: fill a 4-deep FIFO, partial drop, then a write at a full-FIFO pop edge
      fork
         begin
            drive(1'b1, 8'h11, 1'b1, 8'h22);
            sb.push_back(8'h11);
            sb.push_back(8'h22);
            check("t3_stall_cnt2", 32'(stall_req), 32'd0);
            drive(1'b0, 8'h00, 1'b0, 8'h00);
            drive(1'b1, 8'h33, 1'b1, 8'h44);
            sb.push_back(8'h33);
            sb.push_back(8'h44);
            check("t3_stall_cnt3", 32'(stall_req), 32'd1);
            check("t3_ovf_before", 32'(overflow), 32'd0);
            drive(1'b1, 8'h55, 1'b1, 8'h66);
            sb.push_back(8'h55);
            check("t3_count_full", 32'(dut.u_fifo.count_q), 32'd4);
            check("t3_ovf_set", 32'(overflow), 32'd1);
            repeat (37) @(posedge CLK);
            #1;
            check("t4_count_before", 32'(dut.u_fifo.count_q), 32'd4);
            drive(1'b1, 8'h77, 1'b0, 8'h00);
            check("t4_count_after", 32'(dut.u_fifo.count_q), 32'd3);
            check("t4_ovf", 32'(overflow), 32'd1);
            check("t4_stall", 32'(stall_req), 32'd1);
         end
         begin
            @(negedge CLK);
            @(posedge CLK);
            recv_frame("t3_0", lat);
            check("t3_0_lat", 32'(lat), 32'd2);
            for (int i = 1; i < 5; i++) begin
               recv_frame($sformatf("t3_%0d", i), lat);
               check($sformatf("t3_%0d_gap", i), 32'(lat), 32'd0);
            end
         end
      join
      repeat (2) @(negedge CLK);
      check("t3_busy_end", 32'(busy), 32'd0);
      check("t3_sb_empty", 32'(sb.size()), 32'd0);

      // 5: reset during data bit 3 with two bytes still queued
      drive(1'b1, 8'hC3, 1'b1, 8'h5A);
      drive(1'b1, 8'h99, 1'b0, 8'h00);
      check("t5_count", 32'(dut.u_fifo.count_q), 32'd2);
      repeat (16) @(posedge CLK);
      @(negedge CLK);
      check("t5_pre_rst_tx", 32'(uart_tx), 32'd0);
      NRST = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      check("t5_tx", 32'(uart_tx), 32'd1);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_stall", 32'(stall_req), 32'd0);
      check("t5_ovf", 32'(overflow), 32'd0);
      NRST = 1'b1;
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge CLK);
         if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      check("t5_quiet", 32'(bad), 32'd0);

      // 6: lane-2-only write takes one slot, then an ordered lane-1 byte
      drive(1'b0, 8'h00, 1'b1, 8'hA3);
      sb.push_back(8'hA3);
      drive(1'b1, 8'h10, 1'b0, 8'h00);
      sb.push_back(8'h10);
      check("t6_count", 32'(dut.u_fifo.count_q), 32'd1);
      recv_frame("t6a", lat);
      check("t6a_lat", 32'(lat), 32'd1);
      recv_frame("t6b", lat);
      check("t6b_gap", 32'(lat), 32'd0);
      @(negedge CLK);
      check("t6_busy_end", 32'(busy), 32'd0);
      check("t6_ovf", 32'(overflow), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_dual_tx.md
Name: uart_dual_tx

Overview:
- Sits downstream of the dual-issue core's memory stage, between the two M-stage store lanes and the board's uart_tx pin.
- Accepts up to two byte writes per cycle to the UART address, one from each lane.
- Buffers them in program order (lane 1 before lane 2) in a 2-write/1-read FIFO.
- Serialises them as 8N1 frames.
- Raises a stall request before the buffer can lose data, so same-cycle UART stores from both lanes are never silently merged.

Parameters:
- CLKS_PER_BIT, 1085, clock cycles per UART bit; 125 MHz / 115200 baud; legal range >= 2.
- FIFO_DEPTH, 16, byte entries; power of two, >= 4.
- PTR_W, 4, log2(FIFO_DEPTH).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- NRST  in  1  reset; synchronous, active-low.
- we1  in  1  lane-1 (older) M-stage store to the UART address.
- data1  in  8  lane-1 byte (store data [7:0]).
- we2  in  1  lane-2 (younger) M-stage store to the UART address.
- data2  in  8  lane-2 byte.
- stall_req  out  1  free entries < 2; the core must stall D/E issue.
- overflow  out  1  sticky; at least one byte was dropped.
- busy  out  1  FIFO non-empty or frame in progress.
- uart_tx  out  1  serial line, idle high, registered.

Behaviour:
Reset (NRST=0 at a rising edge):
- uart_tx=1, state IDLE, FIFO empty (rd_ptr=wr_ptr=0, count=0).
- baud and bit counters 0; overflow=0; busy=0.
- stall_req=0; it is combinational from count, so it reads 0 after reset.
- Reset mid-frame aborts the frame; uart_tx is 1 on the cycle after reset is sampled.

FIFO push:
- free = FIFO_DEPTH - count, taken from the pre-edge count. A pop in the same cycle does not create push credit.
- we1 & we2, free >= 2: write data1 at wr_ptr and data2 at wr_ptr+1; wr_ptr += 2.
- we1 & we2, free == 1: write data1 only; data2 dropped; overflow <= 1.
- Any write with free == 0: all written bytes dropped; overflow <= 1.
- we2 only: data2 takes one slot (no gap).
- Pointers wrap modulo FIFO_DEPTH.
- Next count = count + pushes - pop, with pop from the FSM this cycle.
- stall_req = (count > FIFO_DEPTH-2), combinational.

FIFO pop / FSM (states IDLE, START, DATA, STOP):
- IDLE, count>0: pop head into shift[7:0]; baud_cnt=0; go to START.
  - uart_tx is 0 from the next cycle.
  - A byte pushed at edge N is therefore driven as a start bit from edge N+2.
- START: uart_tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
- DATA: uart_tx=shift[0] for CLKS_PER_BIT cycles; then shift >>= 1, bit_idx += 1. After bit_idx==7 completes, go to STOP.
- STOP: uart_tx=1 for CLKS_PER_BIT cycles.
  - At the end of STOP, if count>0: pop and go straight to START. Back-to-back frames have no idle bit.
  - Otherwise go to IDLE.
- baud_cnt counts 0..CLKS_PER_BIT-1 and resets on each bit boundary.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- busy = (count != 0) | (state != IDLE).
- overflow clears only on reset.

Decomposition:
- State encodings (2-bit), UART_ADDR, and default CLKS_PER_BIT go in the shared define.vh.
- One sub-module: uart_fifo2w, holding the 2-write/1-read FIFO, count, free, and the drop/overflow logic.
- The FSM and serialiser stay in uart_dual_tx.

Test Plan:
1. CLKS_PER_BIT=4; write we1=1, data1=0x55 at edge N.
   -> uart_tx=0 on cycles N+2..N+5.
   -> Data bits LSB-first 1,0,1,0,1,0,1,0, 4 cycles each.
   -> Stop bit high 4 cycles; then IDLE; busy falls after the stop bit.
2. Same cycle we1=1 data1=0x41, we2=1 data2=0x42.
   -> Frame 0x41, then frame 0x42 starting on the cycle right after 0x41's stop bit.
   -> Total 80 cycles of frames; overflow=0.
3. FIFO_DEPTH=4; push pairs while the FSM is busy.
   -> stall_req=1 once count>=3.
   -> With count=3, a dual write stores data1 only; count=4; overflow=1.
   -> Only the stored bytes appear on uart_tx.
4. count=4 (full) and the FSM pops at the same edge a we1 arrives.
   -> Byte dropped; count=3; overflow=1 (no same-cycle credit).
5. Assert NRST=0 for one edge during DATA bit 3 with 2 bytes queued.
   -> Next cycle: uart_tx=1, busy=0, stall_req=0, overflow=0.
   -> No further frames.
6. we2 only, data2=0xA3.
   -> One frame 0xA3 (bits 1,1,0,0,0,1,0,1); the FIFO has no hole.
   -> A following we1=0x10 is transmitted next, in order.
